c1541_track_loader: RTL

Streams one D64 track between the SD block interface and a local track buffer, and serves that buffer to the GCR encoder/decoder through a byte port. It sits directly downstream of the drive's stepper logic: it consumes the 6-bit `track`, the `save_track` pulse and `disk_change`, and produces `busy`, which the GCR stage uses as RAM-ready. The buffer holds whole 512-byte SD blocks, so write-back never corrupts the neighbouring track's half-block.

---
 rtl/c1541_track_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/c1541_track_loader.sv
// D64 track cache between the SD block interface and the GCR byte port.
// Define C1541_SD_WRITEBACK_EN to enable track write-back (save_track, buff_we, sd_wr).
module c1541_track_loader (
    input  logic        clk32,
    input  logic        reset,
    input  logic [5:0]  track,
    input  logic        save_track,
    input  logic        change,
    input  logic [4:0]  sector,
    input  logic [7:0]  buff_addr,
    output logic [7:0]  buff_dout,
    input  logic [7:0]  buff_din,
    input  logic        buff_we,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    output logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr
);

`ifdef C1541_SD_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, XFER} state_t;

    function automatic logic [5:0] clamp_track(input logic [5:0] t);
        if (t == 6'd0) return 6'd1;
        if (t > 6'd40) return 6'd40;
        return t;
    endfunction

    // Track start in 256-byte sectors from the beginning of the image.
    function automatic logic [9:0] track_off(input logic [5:0] t);
        logic [9:0] tw;
        tw = {4'd0, t};
        if (t <= 6'd17) return (tw - 10'd1) * 10'd21;
        if (t <= 6'd24) return 10'd357 + (tw - 10'd18) * 10'd19;
        if (t <= 6'd30) return 10'd490 + (tw - 10'd25) * 10'd18;
        return 10'd598 + (tw - 10'd31) * 10'd17;
    endfunction

    function automatic logic [4:0] track_secs(input logic [5:0] t);
        if (t <= 6'd17) return 5'd21;
        if (t <= 6'd24) return 5'd19;
        if (t <= 6'd30) return 5'd18;
        return 5'd17;
    endfunction

    logic [7:0]  ram [0:8191];

    state_t      state;
    logic [3:0]  k;
    logic [5:0]  cached_track;
    logic        save_pend;
    logic        abort;
    logic        writing;
    logic [8:0]  first_lba;
    logic [3:0]  nblk;
    logic        odd;
    logic        sd_wr_q;

    logic [5:0]  tclamp;
    logic        save_req;
    logic [5:0]  geo_sel;
    logic [9:0]  geo_off;
    logic [4:0]  geo_secs;
    logic [3:0]  geo_nblk;
    logic [12:0] gcr_addr;
    logic [12:0] sd_addr;

    always_comb begin
        tclamp   = clamp_track(track);
        // A save is only meaningful when a valid track is cached and no disk change is underway.
        save_req = WB_EN && (save_pend || save_track) && (cached_track != 6'd0) && !change;
        geo_sel  = save_req ? cached_track : tclamp;
        geo_off  = track_off(geo_sel);
        geo_secs = track_secs(geo_sel);
        geo_nblk = 4'((5'(geo_off[0]) + geo_secs + 5'd1) >> 1);
        gcr_addr = {sector, buff_addr} + {4'd0, odd, 8'd0};
        sd_addr  = {k, sd_buff_addr};
    end

    assign sd_wr = sd_wr_q & WB_EN;

    always_ff @(posedge clk32) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            cached_track <= '0;
            save_pend    <= 1'b0;
            abort        <= 1'b0;
            writing      <= 1'b0;
            first_lba    <= '0;
            nblk         <= '0;
            odd          <= 1'b0;
            sd_rd        <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_lba       <= '0;
            busy         <= 1'b0;
        end else begin
            busy <= (state != IDLE) | save_pend | (tclamp != cached_track);
            if (WB_EN && save_track)
                save_pend <= 1'b1;

            case (state)
                IDLE: begin
                    k     <= '0;
                    abort <= 1'b0;
                    if (change) begin
                        state <= IDLE;
                    end else if (save_req) begin
                        writing   <= 1'b1;
                        first_lba <= geo_off[9:1];
                        odd       <= geo_off[0];
                        nblk      <= geo_nblk;
                        state     <= WR_REQ;
                    end else if (tclamp != cached_track) begin
                        // Nothing valid is cached any more, so a stale save has no target.
                        cached_track <= tclamp;
                        save_pend    <= 1'b0;
                        writing      <= 1'b0;
                        first_lba    <= geo_off[9:1];
                        odd          <= geo_off[0];
                        nblk         <= geo_nblk;
                        state        <= RD_REQ;
                    end
                end
                RD_REQ, WR_REQ: begin
                    sd_lba <= {23'd0, first_lba + {5'd0, k}};
                    if (sd_ack) begin
                        sd_rd   <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state   <= XFER;
                    end else if (state == RD_REQ) begin
                        sd_rd <= 1'b1;
                    end else begin
                        sd_wr_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        k <= k + 4'd1;
                        if ((k + 4'd1 == nblk) || abort) begin
                            state <= IDLE;
                            if (writing)
                                save_pend <= 1'b0;
                        end else begin
                            state <= writing ? WR_REQ : RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A disk change invalidates the cache; the running block finishes first.
            if (change) begin
                save_pend    <= 1'b0;
                cached_track <= '0;
                if (state != IDLE)
                    abort <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk32) begin
        if (state == XFER && !writing && sd_buff_wr)
            ram[sd_addr] <= sd_buff_dout;
        if (WB_EN && buff_we)
            ram[gcr_addr] <= buff_din;
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            buff_dout   <= '0;
            sd_buff_din <= '0;
        end else begin
            buff_dout   <= ram[gcr_addr];
            sd_buff_din <= ram[sd_addr];
        end
    end

endmodule
